// File: rtl/pipe_decode.sv
// Instruction class decoder feeding a 2-entry output FIFO with saturating delivery statistics.
// Latency: 1 cycle from acceptance to out_valid when empty; no combinational in->out path.
// Backpressure: in_ready drops only when both slots hold entries; independent of out_ready.
module pipe_decode #(
    parameter int SYS_EN = 1,
    parameter int CNT_W  = 16,
    localparam int TYPE_W = 9 + 2*SYS_EN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       in_inst,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TYPE_W-1:0] out_type,
    output logic              out_illegal,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic [CNT_W-1:0]  cnt_dec,
    output logic [CNT_W-1:0]  cnt_ill
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    typedef struct packed {
        logic [TYPE_W-1:0] typ;
        logic              illegal;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
    } entry_t;

    function automatic entry_t decode(input logic [31:0] inst);
        entry_t      e;
        logic [10:0] cls;
        cls = '0;
        case (inst[6:0])
            7'b0110011: cls[0]  = 1'b1;
            7'b0000011: cls[1]  = 1'b1;
            7'b0100011: cls[2]  = 1'b1;
            7'b1100011: cls[3]  = 1'b1;
            7'b0010011: cls[4]  = 1'b1;
            7'b1100111: cls[5]  = 1'b1;
            7'b1101111: cls[6]  = 1'b1;
            7'b0110111: cls[7]  = 1'b1;
            7'b0010111: cls[8]  = 1'b1;
            7'b0001111: cls[9]  = 1'b1;
            7'b1110011: cls[10] = 1'b1;
            default:    cls     = '0;
        endcase
        // FENCE/SYSTEM fall through to illegal when not enabled
        if (SYS_EN == 0) cls[10:9] = 2'b00;
        e.typ     = cls[TYPE_W-1:0];
        e.illegal = (cls == 11'd0);
        e.rd      = inst[11:7];
        e.rs1     = inst[19:15];
        e.rs2     = inst[24:20];
        e.funct3  = inst[14:12];
        e.funct7  = inst[31:25];
        return e;
    endfunction

    logic [1:0] state;
    entry_t     head;
    entry_t     tail;
    entry_t     dec;
    logic       accept;
    logic       deliver;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;
    assign dec       = decode(in_inst);

    assign out_type    = head.typ;
    assign out_illegal = head.illegal;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_funct3  = head.funct3;
    assign out_funct7  = head.funct7;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            head    <= '0;
            tail    <= '0;
            cnt_dec <= '0;
            cnt_ill <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            if (deliver && !head.illegal && cnt_dec != '1) cnt_dec <= cnt_dec + 1'b1;
            if (deliver &&  head.illegal && cnt_ill != '1) cnt_ill <= cnt_ill + 1'b1;
            // head register is the output stage, so fields hold while the FIFO is empty
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head  <= dec;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        head <= dec;
                    end else if (accept) begin
                        tail  <= dec;
                        state <= FULL;
                    end else if (deliver) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        head  <= tail;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: doc/pipe_decode.md
PIPE_DECODE -- requirements
Module: pipe_decode

Interface
REQ-001 Parameter SYS_EN, default 1: when 1, FENCE and SYSTEM opcodes are also decoded.
REQ-002 Parameter CNT_W, default 16: width of the statistics counters.
REQ-003 Derived TYPE_W = 9 + 2*SYS_EN.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  instruction present.
REQ-007 in_inst  in  32  raw instruction word.
REQ-008 in_ready  out  1  block accepts in_inst this cycle.
REQ-009 flush  in  1  discard all buffered entries.
REQ-010 out_valid  out  1  decoded entry available.
REQ-011 out_ready  in  1  consumer takes the entry.
REQ-012 out_type  out  TYPE_W  one-hot class, bits 0..8 = r, load, store, branch, itype, jalr, jal, lui, auipc; bits 9..10 = fence, system (SYS_EN=1 only).
REQ-013 out_illegal  out  1  entry is an unrecognised instruction.
REQ-014 out_rd, out_rs1, out_rs2  out  5 each  inst[11:7], inst[19:15], inst[24:20].
REQ-015 out_funct3  out  3  inst[14:12].
REQ-016 out_funct7  out  7  inst[31:25].
REQ-017 cnt_dec  out  CNT_W  count of legal entries delivered.
REQ-018 cnt_ill  out  CNT_W  count of illegal entries delivered.

Function
REQ-019 Opcode map: r 0110011, load 0000011, store 0100011, branch 1100011, itype 0010011, jalr 1100111, jal 1101111, lui 0110111, auipc 0010111, fence 0001111, system 1110011.
REQ-020 Class decode occurs on acceptance; the stored entry holds type, illegal and the field slices.
REQ-021 out_illegal = 1, out_type all-zero, when opcode matches no enabled class; FENCE/SYSTEM with SYS_EN=0 are illegal.
REQ-022 For a legal entry, exactly one bit of out_type is set.
REQ-023 Buffer: 2-entry FIFO; acceptance occurs when in_valid & in_ready; delivery occurs when out_valid & out_ready.
REQ-024 Occupancy states are EMPTY, ONE and FULL: in_ready = (state != FULL); out_valid = (state != EMPTY).
REQ-025 Latency: an accepted instruction appears on the outputs the cycle after acceptance when the FIFO was empty; there is no combinational in-to-out path.
REQ-026 Simultaneous accept and deliver in ONE keeps ONE, with the head advancing to the new entry.
REQ-027 Simultaneous accept and deliver in FULL cannot occur, because in_ready = 0 in FULL.
REQ-028 Output fields are driven from the head entry; when out_valid = 0 they hold their last value and carry no meaning.
REQ-029 Delivery order equals acceptance order.
REQ-030 flush forces EMPTY next cycle and takes priority over accept and deliver in the same cycle; neither the input nor the head is counted.
REQ-031 cnt_dec increments by 1 on each delivery with out_illegal = 0; cnt_ill increments by 1 on each delivery with out_illegal = 1.
REQ-032 Both counters saturate at 2^CNT_W - 1 and never wrap.
REQ-033 in_ready does not depend combinationally on out_ready.

Reset
REQ-034 While rst = 1 at a clock edge: state = EMPTY, out_valid = 0, in_ready = 1 next cycle, cnt_dec = 0, cnt_ill = 0, out_type = 0, out_illegal = 0, field outputs = 0.
REQ-035 rst overrides flush, accept and deliver; entries in flight are dropped and not counted.
REQ-036 The first acceptance after reset is possible in the cycle after rst deasserts.

Verification
REQ-037 in_inst=0x00A00093 (addi) accepted, out_ready=1 -> next cycle out_valid=1, out_type=0x010, out_rd=1, out_rs1=0, out_illegal=0; after delivery cnt_dec=1.
REQ-038 Three back-to-back inputs (add 0x002081B3, lw 0x0000A103, sw 0x0020A023) with out_ready=0 -> in_ready=0 after two acceptances; releasing out_ready delivers add then lw, with type 0x001 then 0x002, then accepts sw.
REQ-039 in_inst=0x0000000F with SYS_EN=1 -> out_type=0x200; same input with SYS_EN=0 -> out_illegal=1, out_type=0, and cnt_ill increments.
REQ-040 FIFO FULL, then flush=1 concurrent with in_valid=1 and out_ready=1 -> next cycle out_valid=0 and in_ready=1, with both counters unchanged.
REQ-041 CNT_W=2, five illegal words 0xFFFFFFFF delivered -> cnt_ill reads 1, 2, 3, 3, 3.
REQ-042 rst=1 asserted while FIFO is ONE -> next cycle out_valid=0, counters=0, and the held entry is never delivered.
